// File: rtl/tmr_vote_mon_pkg.sv
// Shared encodings for the TMR vote monitor: FSM modes and faulty-replica ids.
package tmr_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_TMR    = 2'd1,
    MODE_FAIL   = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    FID_NONE = 2'd0,
    FID_A    = 2'd1,
    FID_B    = 2'd2,
    FID_C    = 2'd3
  } fault_id_e;

endpackage

// File: rtl/tmr_vote_mon_maj3.sv
// Combinational 3-way comparator/voter. Word-level majority by default;
// per-bit majority when TMR_BITWISE_VOTE_EN is defined.
module tmr_maj3
  import tmr_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic         eq_ab,
  output logic         eq_ac,
  output logic         eq_bc,
  output logic [W-1:0] maj,
  output fault_id_e    fid
);

`ifdef TMR_BITWISE_VOTE_EN
  logic [W-1:0] diff;
`endif

  always_comb begin
    eq_ab = (a == b);
    eq_ac = (a == c);
    eq_bc = (b == c);
    fid   = FID_NONE;
`ifdef TMR_BITWISE_VOTE_EN
    maj  = (a & b) | (a & c) | (b & c);
    diff = (a ^ b) | (a ^ c) | (b ^ c);
    // A replica is blamed only if it is the lone dissenter on every differing bit.
    if (diff != '0) begin
      if      ((a ^ maj) == diff) fid = FID_A;
      else if ((b ^ maj) == diff) fid = FID_B;
      else if ((c ^ maj) == diff) fid = FID_C;
    end
`else
    maj = (eq_bc && !eq_ab) ? b : a;
    if      (eq_ab && !eq_bc) fid = FID_C;
    else if (eq_ac && !eq_ab) fid = FID_B;
    else if (eq_bc && !eq_ab) fid = FID_A;
`endif
  end

endmodule

// File: rtl/tmr_vote_mon.sv
// Dynamic-TMR receive monitor: dual-compare in NORMAL, triple vote in TMR, hold in FAIL.
// Optional per-bit TMR voting via TMR_BITWISE_VOTE_EN.
module tmr_vote_mon
  import tmr_pkg::*;
#(
  parameter int cmd_l     = 4,
  parameter int QUIET_CNT = 16,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [2*cmd_l-1:0] cmd_a,
  input  logic [2*cmd_l-1:0] cmd_b,
  input  logic [2*cmd_l-1:0] cmd_c,
  input  logic               clr_fail,
  output logic               out_valid,
  output logic [2*cmd_l-1:0] cmd_out,
  output logic [1:0]         mode,
  output logic               err_corr,
  output logic               err_uncorr,
  output logic [1:0]         fault_id,
  output logic [CNT_W-1:0]   fault_cnt_a,
  output logic [CNT_W-1:0]   fault_cnt_b,
  output logic [CNT_W-1:0]   fault_cnt_c
);

  localparam int          CW        = 2*cmd_l;
  localparam logic [15:0] QUIET_MAX = 16'(QUIET_CNT);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic          eq_ab, eq_ac, eq_bc;
  logic [CW-1:0] maj;
  fault_id_e     maj_fid;

  tmr_maj3 #(.W(CW)) u_maj3 (
    .a(cmd_a), .b(cmd_b), .c(cmd_c),
    .eq_ab(eq_ab), .eq_ac(eq_ac), .eq_bc(eq_bc),
    .maj(maj), .fid(maj_fid)
  );

  mode_e            mode_q, mode_d;
  logic [15:0]      quiet_q, quiet_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    cmd_out_q, cmd_out_d;
  logic             err_corr_q, err_corr_d;
  logic             err_uncorr_q, err_uncorr_d;
  fault_id_e        fault_id_q, fault_id_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d, cnt_c_q, cnt_c_d;

  logic          corr, uncorr;
  logic [CW-1:0] vote;
  fault_id_e     fid_v;

  // Classify the current sample under the rule of the current mode.
  always_comb begin
    corr   = 1'b0;
    uncorr = 1'b0;
    vote   = cmd_a;
    fid_v  = FID_NONE;
    case (mode_q)
      MODE_NORMAL: begin
        if (eq_ab) begin
          vote = cmd_a;
        end else if (eq_ac || eq_bc) begin
          corr  = 1'b1;
          vote  = maj;
          fid_v = maj_fid;
        end else begin
          uncorr = 1'b1;
        end
      end
      MODE_TMR: begin
        if (eq_ab && eq_bc) begin
          vote = cmd_a;
        end else begin
`ifdef TMR_BITWISE_VOTE_EN
          corr  = 1'b1;
          vote  = maj;
          fid_v = maj_fid;
`else
          if (eq_ab || eq_ac || eq_bc) begin
            corr  = 1'b1;
            vote  = maj;
            fid_v = maj_fid;
          end else begin
            uncorr = 1'b1;
          end
`endif
        end
      end
      default: uncorr = 1'b1;
    endcase
  end

  always_comb begin
    mode_d       = mode_q;
    quiet_d      = quiet_q;
    out_valid_d  = in_valid;
    cmd_out_d    = cmd_out_q;
    err_corr_d   = 1'b0;
    err_uncorr_d = 1'b0;
    fault_id_d   = FID_NONE;
    cnt_a_d      = cnt_a_q;
    cnt_b_d      = cnt_b_q;
    cnt_c_d      = cnt_c_q;
    if (in_valid) begin
      if (uncorr) begin
        err_uncorr_d = 1'b1;
        mode_d       = MODE_FAIL;
      end else begin
        cmd_out_d = vote;
        if (corr) begin
          err_corr_d = 1'b1;
          fault_id_d = fid_v;
          quiet_d    = '0;
          mode_d     = MODE_TMR;
          if (fid_v == FID_A && cnt_a_q != CNT_SAT) cnt_a_d = cnt_a_q + 1'b1;
          if (fid_v == FID_B && cnt_b_q != CNT_SAT) cnt_b_d = cnt_b_q + 1'b1;
          if (fid_v == FID_C && cnt_c_q != CNT_SAT) cnt_c_d = cnt_c_q + 1'b1;
        end else if (mode_q == MODE_TMR) begin
          if (quiet_q + 16'd1 == QUIET_MAX) begin
            mode_d  = MODE_NORMAL;
            quiet_d = '0;
          end else begin
            quiet_d = quiet_q + 16'd1;
          end
        end
      end
    end
    // The sample in the same cycle was already handled under FAIL rules above.
    if (mode_q == MODE_FAIL && clr_fail) begin
      mode_d  = MODE_TMR;
      quiet_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q       <= MODE_NORMAL;
      quiet_q      <= '0;
      out_valid_q  <= 1'b0;
      cmd_out_q    <= '0;
      err_corr_q   <= 1'b0;
      err_uncorr_q <= 1'b0;
      fault_id_q   <= FID_NONE;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      cnt_c_q      <= '0;
    end else begin
      mode_q       <= mode_d;
      quiet_q      <= quiet_d;
      out_valid_q  <= out_valid_d;
      cmd_out_q    <= cmd_out_d;
      err_corr_q   <= err_corr_d;
      err_uncorr_q <= err_uncorr_d;
      fault_id_q   <= fault_id_d;
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
      cnt_c_q      <= cnt_c_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign cmd_out     = cmd_out_q;
  assign mode        = mode_q;
  assign err_corr    = err_corr_q;
  assign err_uncorr  = err_uncorr_q;
  assign fault_id    = fault_id_q;
  assign fault_cnt_a = cnt_a_q;
  assign fault_cnt_b = cnt_b_q;
  assign fault_cnt_c = cnt_c_q;

endmodule

// File: tb/tb_tmr_vote_mon.sv
// Directed bench for tmr_vote_mon (cmd_l=4, QUIET_CNT=4, CNT_W=2).
module tb_tmr_vote_mon;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] cmd_a = '0, cmd_b = '0, cmd_c = '0;
  logic       clr_fail = 1'b0;
  logic       out_valid, err_corr, err_uncorr;
  logic [7:0] cmd_out;
  logic [1:0] mode, fault_id, fault_cnt_a, fault_cnt_b, fault_cnt_c;

  int n_pass = 0;
  int n_tot  = 0;

  tmr_vote_mon #(.cmd_l(4), .QUIET_CNT(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .clr_fail(clr_fail),
    .out_valid(out_valid), .cmd_out(cmd_out), .mode(mode),
    .err_corr(err_corr), .err_uncorr(err_uncorr), .fault_id(fault_id),
    .fault_cnt_a(fault_cnt_a), .fault_cnt_b(fault_cnt_b), .fault_cnt_c(fault_cnt_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
  endtask

  // Drive one sample for one cycle; results are visible on return.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic clr = 1'b0);
    @(negedge clk);
    in_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_c = c; clr_fail = clr;
    @(negedge clk);
    in_valid = 1'b0; clr_fail = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ov"},  out_valid,   0);
    chk({tag, "_cmd"}, cmd_out,     0);
    chk({tag, "_md"},  mode,        0);
    chk({tag, "_ec"},  err_corr,    0);
    chk({tag, "_eu"},  err_uncorr,  0);
    chk({tag, "_fid"}, fault_id,    0);
    chk({tag, "_ca"},  fault_cnt_a, 0);
    chk({tag, "_cb"},  fault_cnt_b, 0);
    chk({tag, "_cc"},  fault_cnt_c, 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    chk_zero("rst");
    rst = 1'b0;

    // NORMAL, a==b: c ignored
    send(8'h35, 8'h35, 8'hFF);
    chk("n_clean_ov",  out_valid, 1);
    chk("n_clean_cmd", cmd_out, 8'h35);
    chk("n_clean_ec",  err_corr, 0);
    chk("n_clean_fid", fault_id, 0);
    chk("n_clean_md",  mode, 0);
    @(negedge clk);
    chk("idle_ov",  out_valid, 0);
    chk("idle_cmd", cmd_out, 8'h35);

    // clr_fail outside FAIL is ignored
    clr_fail = 1'b1; @(negedge clk); clr_fail = 1'b0; @(negedge clk);
    chk("clr_norm_md", mode, 0);

    // NORMAL, B disagrees -> TMR
    send(8'h35, 8'h36, 8'h35);
    chk("n_fb_cmd", cmd_out, 8'h35);
    chk("n_fb_ec",  err_corr, 1);
    chk("n_fb_fid", fault_id, 2);
    chk("n_fb_cb",  fault_cnt_b, 1);
    chk("n_fb_md",  mode, 1);

    // TMR quiet count, restarted by a C fault on the third sample
    send(8'h12, 8'h12, 8'h12);
    send(8'h12, 8'h12, 8'h12);
    chk("t_q2_md", mode, 1);
    send(8'h12, 8'h12, 8'h13);
    chk("t_fc_cmd", cmd_out, 8'h12);
    chk("t_fc_fid", fault_id, 3);
    chk("t_fc_ec",  err_corr, 1);
    chk("t_fc_cc",  fault_cnt_c, 1);
    send(8'h12, 8'h12, 8'h12);
    send(8'h12, 8'h12, 8'h12);
    send(8'h12, 8'h12, 8'h12);
    chk("t_q3_md", mode, 1);
    send(8'h12, 8'h12, 8'h12);
    chk("t_q4_md", mode, 0);
    chk("t_q4_ec", err_corr, 0);

    // NORMAL, all differ -> FAIL, cmd_out held
    send(8'h11, 8'h22, 8'h33);
    chk("n_unc_eu",  err_uncorr, 1);
    chk("n_unc_ec",  err_corr, 0);
    chk("n_unc_fid", fault_id, 0);
    chk("n_unc_cmd", cmd_out, 8'h12);
    chk("n_unc_md",  mode, 2);
    send(8'h44, 8'h44, 8'h44);
    chk("f_ov",  out_valid, 1);
    chk("f_eu",  err_uncorr, 1);
    chk("f_cmd", cmd_out, 8'h12);
    chk("f_md",  mode, 2);
    send(8'h01, 8'h02, 8'h02);
    chk("f_frz_ca", fault_cnt_a, 0);
    // Sample coincident with clr_fail still obeys FAIL rules
    send(8'h55, 8'h55, 8'h55, 1'b1);
    chk("f_clr_eu",  err_uncorr, 1);
    chk("f_clr_cmd", cmd_out, 8'h12);
    chk("f_clr_md",  mode, 1);

`ifdef TMR_BITWISE_VOTE_EN
    send(8'h0F, 8'h3C, 8'hF0);
    chk("bw_cmd", cmd_out, 8'h3C);
    chk("bw_ec",  err_corr, 1);
    chk("bw_eu",  err_uncorr, 0);
    chk("bw_fid", fault_id, 0);
    chk("bw_md",  mode, 1);
    chk("bw_ca",  fault_cnt_a, 0);
`else
    send(8'h11, 8'h22, 8'h33);
    chk("t_unc_eu",  err_uncorr, 1);
    chk("t_unc_cmd", cmd_out, 8'h12);
    chk("t_unc_md",  mode, 2);
    @(negedge clk);
    clr_fail = 1'b1; @(negedge clk); clr_fail = 1'b0;
    chk("t_clr_md", mode, 1);
    chk("t_clr_ov", out_valid, 0);
`endif

    // Saturation of A counter in TMR (CNT_W=2)
    send(8'h01, 8'h02, 8'h02);
    chk("sat1_ca", fault_cnt_a, 1);
    chk("sat1_cmd", cmd_out, 8'h02);
    chk("sat1_fid", fault_id, 1);
    send(8'h01, 8'h02, 8'h02);
    send(8'h01, 8'h02, 8'h02);
    chk("sat3_ca", fault_cnt_a, 3);
    send(8'h01, 8'h02, 8'h02);
    send(8'h01, 8'h02, 8'h02);
    chk("sat5_ca", fault_cnt_a, 3);
    chk("sat5_cb", fault_cnt_b, 1);
    chk("sat5_md", mode, 1);

    // Reset while a result is in flight
    @(negedge clk);
    in_valid = 1'b1; cmd_a = 8'h77; cmd_b = 8'h78; cmd_c = 8'h77;
    @(posedge clk);
    #1 rst = 1'b1; in_valid = 1'b0;
    #1 chk_zero("mrst");
    @(negedge clk);
    chk("mrst_ov2", out_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ov", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running exp finished");
    $fatal(1);
  end

endmodule
